// File: rtl/tt_sel_driver_pkg.sv
// Shared definitions for the design-select driver: state encodings and parameter defaults.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package tt_sel_driver_pkg;

    // Default design-address width (mux id and block id concatenated).
    localparam int TT_SEL_ADDR_W_DEF    = 10;
    // Default clk cycles per protocol phase.
    localparam int TT_SEL_PULSE_CYC_DEF = 2;

    // Sequencer states, 3-bit encoding.
    typedef enum logic [2:0] {
        TT_SEL_ST_IDLE   = 3'd0,
        TT_SEL_ST_DIS    = 3'd1,
        TT_SEL_ST_RST    = 3'd2,
        TT_SEL_ST_REL    = 3'd3,
        TT_SEL_ST_INC_HI = 3'd4,
        TT_SEL_ST_INC_LO = 3'd5,
        TT_SEL_ST_SETTLE = 3'd6,
        TT_SEL_ST_ENA    = 3'd7
    } tt_sel_st_e;

endpackage

// File: rtl/tt_sel_phase_timer.sv
// Loadable phase down-counter: load sets the count to LOAD_VAL, expire pulses when it reaches 0.
// Latency: expire is high LOAD_VAL+1 cycles after the load edge.
// Backpressure: none; load always wins over counting.
// Ports: clk, rst_n (sync, active low), load (restart the phase), expire (phase elapsed).
module tt_sel_phase_timer #(
    parameter int CNT_W    = 8,
    parameter int LOAD_VAL = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_armed;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else if (load) begin
            r_cnt   <= CNT_W'(LOAD_VAL);
            r_armed <= 1'b1;
        end else if (r_armed) begin
            // Disarm after reaching zero so expire is a single-cycle pulse.
            if (r_cnt == '0) begin
                r_armed <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign expire = r_armed && (r_cnt == '0);

endmodule

// File: rtl/tt_sel_driver.sv
// Design-select initiator: disables, resets the select counter, pulses inc N times, re-enables.
// Latency: done 4T+2T*N+1 cycles after accept (2T+2T*N+1 in incremental mode).
// Backpressure: req_ready high only in IDLE; requests during a sequence are not accepted.
// Optional feature macro: TT_SEL_INCR_SKIP_EN (incremental select from the current address).
// Ports: clk, rst_n (sync, active low); req_valid/req_ready/req_addr host request;
//        ctrl_sel_rst_n/ctrl_sel_inc/ctrl_ena to the controller pads; busy, done, cur_addr, cur_valid status.
module tt_sel_driver
    import tt_sel_driver_pkg::*;
#(
    parameter int ADDR_W    = TT_SEL_ADDR_W_DEF,
    parameter int PULSE_CYC = TT_SEL_PULSE_CYC_DEF,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              cur_valid
);

    tt_sel_st_e        r_state;
    tt_sel_st_e        w_next;
    logic              r_ready;
    logic [ADDR_W-1:0] r_n;
    logic [ADDR_W-1:0] r_addr;
    logic              r_sel_rst_n;
    logic              r_sel_inc;
    logic              r_ena;
    logic              r_done;
    logic [ADDR_W-1:0] r_cur_addr;
    logic              r_cur_valid;
    logic              w_accept;
    logic              w_load;
    logic              w_expire;

`ifdef TT_SEL_INCR_SKIP_EN
    logic              r_incr;
    logic              w_incr_ok;
    logic [ADDR_W-1:0] w_diff;

    // Counting up from the currently selected design avoids the reset phase.
    assign w_incr_ok = r_cur_valid && (req_addr >= r_cur_addr);
    assign w_diff    = req_addr - r_cur_addr;
`endif

    assign w_accept = req_valid && (r_state == TT_SEL_ST_IDLE);
    // Every state change restarts the phase timer.
    assign w_load   = (w_next != r_state);

    tt_sel_phase_timer #(
        .CNT_W    (CNT_W),
        .LOAD_VAL (PULSE_CYC - 1)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_load),
        .expire (w_expire)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            TT_SEL_ST_IDLE:   if (req_valid) w_next = TT_SEL_ST_DIS;
            TT_SEL_ST_DIS: begin
                if (w_expire) begin
`ifdef TT_SEL_INCR_SKIP_EN
                    if (r_incr) w_next = (r_n != '0) ? TT_SEL_ST_INC_HI : TT_SEL_ST_SETTLE;
                    else
`endif
                    w_next = TT_SEL_ST_RST;
                end
            end
            TT_SEL_ST_RST:    if (w_expire) w_next = TT_SEL_ST_REL;
            TT_SEL_ST_REL:    if (w_expire) w_next = (r_n != '0) ? TT_SEL_ST_INC_HI : TT_SEL_ST_SETTLE;
            TT_SEL_ST_INC_HI: if (w_expire) w_next = TT_SEL_ST_INC_LO;
            // r_n was already decremented when INC_HI ended.
            TT_SEL_ST_INC_LO: if (w_expire) w_next = (r_n != '0) ? TT_SEL_ST_INC_HI : TT_SEL_ST_SETTLE;
            TT_SEL_ST_SETTLE: if (w_expire) w_next = TT_SEL_ST_ENA;
            TT_SEL_ST_ENA:    w_next = TT_SEL_ST_IDLE;
            default:          w_next = TT_SEL_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= TT_SEL_ST_IDLE;
            r_ready     <= 1'b1;
            r_n         <= '0;
            r_addr      <= '0;
            r_sel_rst_n <= 1'b0;
            r_sel_inc   <= 1'b0;
            r_ena       <= 1'b0;
            r_done      <= 1'b0;
            r_cur_addr  <= '0;
            r_cur_valid <= 1'b0;
`ifdef TT_SEL_INCR_SKIP_EN
            r_incr      <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == TT_SEL_ST_IDLE);

            if (w_accept) begin
                r_addr <= req_addr;
`ifdef TT_SEL_INCR_SKIP_EN
                r_incr <= w_incr_ok;
                r_n    <= w_incr_ok ? w_diff : req_addr;
`else
                r_n    <= req_addr;
`endif
            end else if ((r_state == TT_SEL_ST_INC_HI) && w_expire) begin
                r_n <= r_n - 1'b1;
            end

            // Pad outputs follow the state one cycle later so every pad is a flop.
            r_done <= 1'b0;
            case (r_state)
                TT_SEL_ST_DIS:    r_ena       <= 1'b0;
                TT_SEL_ST_RST:    r_sel_rst_n <= 1'b0;
                TT_SEL_ST_REL:    r_sel_rst_n <= 1'b1;
                TT_SEL_ST_INC_HI: r_sel_inc   <= 1'b1;
                TT_SEL_ST_INC_LO: r_sel_inc   <= 1'b0;
                TT_SEL_ST_ENA: begin
                    r_ena       <= 1'b1;
                    r_done      <= 1'b1;
                    r_cur_addr  <= r_addr;
                    r_cur_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready      = r_ready;
    assign busy           = ~r_ready;
    assign done           = r_done;
    assign ctrl_sel_rst_n = r_sel_rst_n;
    assign ctrl_sel_inc   = r_sel_inc;
    assign ctrl_ena       = r_ena;
    assign cur_addr       = r_cur_addr;
    assign cur_valid      = r_cur_valid;

endmodule
